mul_share_arbiter: RTL

- Shares one instance of the 4-bit unsigned combinational multiplier `array_mul` (ports a, b, s) among NREQ requesters.
- Round-robin arbitration with a per-requester valid/ready request handshake and a single tagged response channel with valid/ready.
- Operands and product are registered around the multiplier, so `array_mul` sits between two register stages.

---
 rtl/mul_share_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one 4x4 array multiplier among NREQ requesters.
// Operands and product are registered around the multiplier; one tagged response channel.

module array_mul (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] s
);
    // Shift-and-add of the four partial-product rows.
    always_comb begin
        s = '0;
        for (int i = 0; i < 4; i++) begin
            s = s + ({4'b0000, a & {4{b[i]}}} << i);
        end
    end
endmodule

module mul_share_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [4*NREQ-1:0]   req_a,
    input  logic [4*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]     req_ready,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [7:0]          rsp_prod,
    output logic [IDW-1:0]      rsp_id,
    output logic                busy
);
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StCalc = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    logic [1:0]     state_q, state_d;
    logic [3:0]     op_a_q, op_a_d;
    logic [3:0]     op_b_q, op_b_d;
    logic [IDW-1:0] op_id_q, op_id_d;
    logic [IDW-1:0] last_grant_q, last_grant_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [7:0]     rsp_prod_q, rsp_prod_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;

    logic           hi_found, lo_found, grant_found;
    logic [IDW-1:0] hi_idx, lo_idx, grant_idx;
    logic [3:0]     grant_a, grant_b;
    logic [7:0]     mul_s;

    // Lowest valid index above the last grant wins; otherwise wrap to the lowest at or below it.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                if (IDW'(i) > last_grant_q) begin
                    hi_found = 1'b1;
                    hi_idx   = IDW'(i);
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = IDW'(i);
                end
            end
        end
        grant_found = hi_found | lo_found;
        grant_idx   = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        grant_a = '0;
        grant_b = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (IDW'(i) == grant_idx) begin
                grant_a = req_a[4*i +: 4];
                grant_b = req_b[4*i +: 4];
            end
        end
    end

    // Gated by rst_n so no grant is ever shown while reset is held.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            req_ready[i] = rst_n && (state_q == StIdle) && grant_found &&
                           (IDW'(i) == grant_idx);
        end
    end

    array_mul u_array_mul (
        .a (op_a_q),
        .b (op_b_q),
        .s (mul_s)
    );

    always_comb begin
        state_d      = state_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_id_d      = op_id_q;
        last_grant_d = last_grant_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_prod_d   = rsp_prod_q;
        rsp_id_d     = rsp_id_q;
        unique case (state_q)
            StIdle: begin
                if (grant_found) begin
                    op_a_d       = grant_a;
                    op_b_d       = grant_b;
                    op_id_d      = grant_idx;
                    last_grant_d = grant_idx;
                    state_d      = StCalc;
                end
            end
            StCalc: begin
                rsp_prod_d  = mul_s;
                rsp_id_d    = op_id_q;
                rsp_valid_d = 1'b1;
                state_d     = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_id_q      <= '0;
            last_grant_q <= IDW'(NREQ - 1);
            rsp_valid_q  <= 1'b0;
            rsp_prod_q   <= '0;
            rsp_id_q     <= '0;
        end else begin
            state_q      <= state_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_id_q      <= op_id_d;
            last_grant_q <= last_grant_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_prod_q   <= rsp_prod_d;
            rsp_id_q     <= rsp_id_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_prod  = rsp_prod_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q == StCalc) || (state_q == StResp);

endmodule
